// File: rtl/scc_cmd_master.sv
// scc_cmd_master: FIFO-buffered bus initiator for the SCC req/ack slave port.
// Optional ack watchdog enabled by defining SCC_CMD_TIMEOUT_EN.
module scc_cmd_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wr,
    input  logic [7:0]                    cmd_adr,
    input  logic [7:0]                    cmd_dat,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_dat,
    output logic                          rsp_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          req,
    input  logic                          ack,
    output logic                          wrt,
    output logic [7:0]                    adr,
    output logic [7:0]                    dbo,
    input  logic [7:0]                    dbi
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, GAP = 2'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYCLES < 1 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("scc_cmd_master: illegal parameter value");
    end

    logic [1:0]    state;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [GW-1:0] gap_cnt;
    logic          push, pop;

    assign cmd_ready = fifo_level != (AW+1)'(FIFO_DEPTH);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = state == IDLE && fifo_level != '0;
    assign busy      = fifo_level != '0 || state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wptr] <= {cmd_wr, cmd_adr, cmd_dat};

`ifdef SCC_CMD_TIMEOUT_EN
    logic [7:0] timer;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            gap_cnt    <= '0;
            req        <= 1'b0;
            wrt        <= 1'b0;
            adr        <= '0;
            dbo        <= '0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
`ifdef SCC_CMD_TIMEOUT_EN
            timer       <= '0;
            rsp_timeout <= 1'b0;
`endif
        end else begin
            if (push) wptr <= wptr + 1'b1;
            fifo_level <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            rsp_valid  <= 1'b0;
`ifdef SCC_CMD_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state)
                IDLE: if (pop) begin
                    {wrt, adr, dbo} <= mem[rptr];
                    rptr  <= rptr + 1'b1;
                    req   <= 1'b1;
                    state <= REQ;
`ifdef SCC_CMD_TIMEOUT_EN
                    timer <= '0;
`endif
                end
                REQ: if (ack) begin
                    req   <= 1'b0;
                    state <= DONE;
                    if (!wrt) begin
                        rsp_dat   <= dbi;
                        rsp_valid <= 1'b1;
                    end
                end
`ifdef SCC_CMD_TIMEOUT_EN
                else if (timer == 8'(TIMEOUT - 1)) begin
                    req         <= 1'b0;
                    rsp_timeout <= 1'b1;
                    gap_cnt     <= '0;
                    state       <= GAP;
                end else timer <= timer + 1'b1;
`endif
                DONE: begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                default: begin
                    // leave only once the slave has released ack so its next req edge is fresh
                    if (gap_cnt == GW'(GAP_CYCLES - 1) && !ack) begin
                        {wrt, adr, dbo} <= '0;
                        state <= IDLE;
                    end else if (gap_cnt != GW'(GAP_CYCLES - 1)) gap_cnt <= gap_cnt + 1'b1;
                end
            endcase
        end
    end
endmodule
